cell_writeback: RTL and testbench

CELL_WRITEBACK -- requirements
Module: cell_writeback

---
 rtl/cell_writeback.sv | 133 +++++++++++++
 tb/tb_cell_writeback.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cell_writeback.sv
// cell_writeback: streams the selected 32-bit elements of a 2x2 result cell to word memory.
// Latency: first write request in the cycle after the cell is accepted, then one element per acked cycle.
// Backpressure: cell_ready only in IDLE; a write is held stable until mem_ack, one element per ack.
//
// Optional feature macro: CELL_WB_SKIP_ZERO_EN (skip elements equal to +0.0).
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   cell_in[129:0]      {tag[1:0], c22, c21, c12, c11}
//   cell_valid/ready    cell handshake; base_addr/row_stride travel with the cell
//   mem_we/addr/wdata   write request, held until mem_ack
//   mem_ack             memory accepted the current write
//   tile_done           one-cycle pulse after the last element of a cell completes
//   tiles_written       running count of completed cells
module cell_writeback #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [129:0]      cell_in,
  input  logic              cell_valid,
  output logic              cell_ready,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              tile_done,
  output logic [CNT_W-1:0]  tiles_written
);

  typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [127:0]      r_data;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_stride;
  logic [3:0]        r_pend;   // elements still to write: bit0 c11, bit1 c12, bit2 c21, bit3 c22
  logic              r_done;
  logic [CNT_W-1:0]  r_count;

  logic [3:0]        w_mask;
  logic [3:0]        w_first;
  logic [3:0]        w_rest;
  logic              w_fire;
  logic              w_transfer;

  // Element set for an incoming cell, chosen by shape tag.
  always_comb begin
    w_mask = 4'b0001;
    case (cell_in[129:128])
      2'b00: w_mask = 4'b0001;
      2'b01: w_mask = 4'b0011;
      2'b10: w_mask = 4'b0101;
      2'b11: w_mask = 4'b1111;
      default: w_mask = 4'b0001;
    endcase
`ifdef CELL_WB_SKIP_ZERO_EN
    // Positive zero only; -0.0 (32'h80000000) is still written.
    w_mask = w_mask & {cell_in[127:96] != 32'h0, cell_in[95:64] != 32'h0,
                       cell_in[63:32]  != 32'h0, cell_in[31:0]  != 32'h0};
`endif
  end

  // Lowest pending bit is the element on the bus; clearing it yields what remains.
  assign w_first    = r_pend & (~r_pend + 4'd1);
  assign w_rest     = r_pend & ~w_first;
  assign w_fire     = mem_we & mem_ack;
  assign w_transfer = cell_ready & cell_valid;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic. An empty element set (all skipped) leaves WRITE after one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cell_valid) w_next = S_WRITE;
      S_WRITE: if (r_pend == 4'd0 || (w_fire && w_rest == 4'd0)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cell_ready = (r_state == S_IDLE);
    mem_we     = (r_state == S_WRITE) && (r_pend != 4'd0);
    mem_addr   = '0;
    mem_wdata  = 32'h0;
    if (mem_we) begin
      case (w_first)
        4'b0001: begin mem_addr = r_base;                             mem_wdata = r_data[31:0];   end
        4'b0010: begin mem_addr = r_base + ADDR_W'(1);                mem_wdata = r_data[63:32];  end
        4'b0100: begin mem_addr = r_base + r_stride;                  mem_wdata = r_data[95:64];  end
        4'b1000: begin mem_addr = r_base + r_stride + ADDR_W'(1);     mem_wdata = r_data[127:96]; end
        default: begin mem_addr = '0;                                 mem_wdata = 32'h0;          end
      endcase
    end
  end

  // Captured cell, progress mask, completion pulse and counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data   <= '0;
      r_base   <= '0;
      r_stride <= '0;
      r_pend   <= '0;
      r_done   <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_transfer) begin
        r_data   <= cell_in[127:0];
        r_base   <= base_addr;
        r_stride <= row_stride;
        r_pend   <= w_mask;
      end else if (w_fire) begin
        r_pend   <= w_rest;
      end
      r_done <= (r_state == S_WRITE) && (w_next == S_IDLE);
      if ((r_state == S_WRITE) && (w_next == S_IDLE)) r_count <= r_count + CNT_W'(1);
    end
  end

  assign tile_done     = r_done;
  assign tiles_written = r_count;

endmodule

// File: tb/tb_cell_writeback.sv
// tb_cell_writeback: directed checks of cell_writeback (ordering, shapes, stalls, wrap, zeros, reset).
// Latency: inputs driven and outputs sampled on the falling edge of clk.
// Backpressure: mem_ack driven per step; stall sequences hold it low for three cycles per element.
module tb_cell_writeback;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [129:0] cell_in = '0;
  logic         cell_valid = 1'b0;
  logic         cell_ready;
  logic [15:0]  base_addr = '0;
  logic [15:0]  row_stride = '0;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ack = 1'b0;
  logic         tile_done;
  logic [15:0]  tiles_written;

  int n_cmp = 0;
  int n_err = 0;

  cell_writeback #(.ADDR_W(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cell_in(cell_in), .cell_valid(cell_valid),
    .cell_ready(cell_ready), .base_addr(base_addr), .row_stride(row_stride),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .tile_done(tile_done), .tiles_written(tiles_written)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a cell at this falling edge; return one edge later with valid dropped.
  task automatic send(input logic [1:0] tag, input logic [31:0] c11, input logic [31:0] c12,
                      input logic [31:0] c21, input logic [31:0] c22,
                      input logic [15:0] base, input logic [15:0] stride);
    cell_in    = {tag, c22, c21, c12, c11};
    base_addr  = base;
    row_stride = stride;
    cell_valid = 1'b1;
    @(negedge clk);
    cell_valid = 1'b0;
    cell_in    = '0;
    base_addr  = 16'hDEAD;
    row_stride = 16'hBEEF;
  endtask

  task automatic exp_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, ".we"},    32'(mem_we), 1);
    chk({tag, ".addr"},  32'(mem_addr), a);
    chk({tag, ".data"},  mem_wdata, d);
    chk({tag, ".ready"}, 32'(cell_ready), 0);
    @(negedge clk);
  endtask

  task automatic exp_done(input string tag, input logic [31:0] cnt);
    chk({tag, ".done_we"},    32'(mem_we), 0);
    chk({tag, ".done_addr"},  32'(mem_addr), 0);
    chk({tag, ".done_data"},  mem_wdata, 0);
    chk({tag, ".done"},       32'(tile_done), 1);
    chk({tag, ".ready"},      32'(cell_ready), 1);
    chk({tag, ".count"},      32'(tiles_written), cnt);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(tile_done), 0);
  endtask

  initial begin
    logic [31:0] st_a [4];
    logic [31:0] st_d [4];

    // Reset state
    #3;
    chk("rst.ready", 32'(cell_ready), 1);
    chk("rst.we",    32'(mem_we), 0);
    chk("rst.addr",  32'(mem_addr), 0);
    chk("rst.data",  mem_wdata, 0);
    chk("rst.done",  32'(tile_done), 0);
    chk("rst.count", 32'(tiles_written), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 2x2 with ack tied high: four back-to-back writes
    mem_ack = 1'b1;
    send(2'b11, 'h3F800000, 'h40000000, 'h40400000, 'h40800000, 16'h0010, 16'd8);
    exp_wr("t22.c11", 'h10, 'h3F800000);
    exp_wr("t22.c12", 'h11, 'h40000000);
    exp_wr("t22.c21", 'h18, 'h40400000);
    exp_wr("t22.c22", 'h19, 'h40800000);
    exp_done("t22", 1);

    // 1x2 and 2x1
    send(2'b01, 'h11111111, 'h22222222, 'h33333333, 'h44444444, 16'h0020, 16'd8);
    exp_wr("t12.c11", 'h20, 'h11111111);
    exp_wr("t12.c12", 'h21, 'h22222222);
    exp_done("t12", 2);
    send(2'b10, 'h55555555, 'h66666666, 'h77777777, 'h88888888, 16'h0020, 16'd4);
    exp_wr("t21.c11", 'h20, 'h55555555);
    exp_wr("t21.c21", 'h24, 'h77777777);
    exp_done("t21", 3);

    // Stalled acks with a competing cell offered throughout
    mem_ack = 1'b0;
    send(2'b11, 'hA0000001, 'hA0000002, 'hA0000003, 'hA0000004, 16'h0040, 16'h0010);
    st_a = '{'h40, 'h41, 'h50, 'h51};
    st_d = '{'hA0000001, 'hA0000002, 'hA0000003, 'hA0000004};
    cell_in    = {2'b00, 32'hBAD0BAD0, 32'hBAD0BAD0, 32'hBAD0BAD0, 32'hBAD0BAD0};
    base_addr  = 16'h0123;
    row_stride = 16'h0007;
    cell_valid = 1'b1;
    for (int e = 0; e < 4; e++) begin
      mem_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
        chk("stall.we",    32'(mem_we), 1);
        chk("stall.addr",  32'(mem_addr), st_a[e]);
        chk("stall.data",  mem_wdata, st_d[e]);
        chk("stall.ready", 32'(cell_ready), 0);
        @(negedge clk);
      end
      mem_ack = 1'b1;
      if (e == 3) cell_valid = 1'b0;
      chk("stall.ack_addr", 32'(mem_addr), st_a[e]);
      chk("stall.ack_data", mem_wdata, st_d[e]);
      @(negedge clk);
    end
    exp_done("stall", 4);
    chk("stall.no_new", 32'(mem_we), 0);

    // Address wrap-around
    send(2'b11, 'h00000001, 'h00000002, 'h00000003, 'h00000004, 16'hFFFF, 16'd1);
    exp_wr("wrap.c11", 'hFFFF, 'h1);
    exp_wr("wrap.c12", 'h0000, 'h2);
    exp_wr("wrap.c21", 'h0000, 'h3);
    exp_wr("wrap.c22", 'h0001, 'h4);
    exp_done("wrap", 5);

    // Zero elements
    send(2'b11, 'h3F800000, 'h00000000, 'h00000000, 'h40800000, 16'h0010, 16'd8);
`ifdef CELL_WB_SKIP_ZERO_EN
    exp_wr("zero.c11", 'h10, 'h3F800000);
    exp_wr("zero.c22", 'h19, 'h40800000);
`else
    exp_wr("zero.c11", 'h10, 'h3F800000);
    exp_wr("zero.c12", 'h11, 'h0);
    exp_wr("zero.c21", 'h18, 'h0);
    exp_wr("zero.c22", 'h19, 'h40800000);
`endif
    exp_done("zero", 6);

    // Single-element cell that is zero
    send(2'b00, 'h00000000, 'h12345678, 'h12345678, 'h12345678, 16'h0030, 16'd8);
`ifdef CELL_WB_SKIP_ZERO_EN
    chk("allzero.we",    32'(mem_we), 0);
    chk("allzero.ready", 32'(cell_ready), 0);
    @(negedge clk);
`else
    exp_wr("allzero.c11", 'h30, 'h0);
`endif
    exp_done("allzero", 7);

    // Reset during the second of four writes
    send(2'b11, 'h3F800000, 'h40000000, 'h40400000, 'h40800000, 16'h0010, 16'd8);
    exp_wr("mrst.c11", 'h10, 'h3F800000);
    chk("mrst.c12_addr", 32'(mem_addr), 'h11);
    #2 reset = 1'b0;
    #1;
    chk("mrst.we",    32'(mem_we), 0);
    chk("mrst.addr",  32'(mem_addr), 0);
    chk("mrst.data",  mem_wdata, 0);
    chk("mrst.ready", 32'(cell_ready), 1);
    chk("mrst.done",  32'(tile_done), 0);
    chk("mrst.count", 32'(tiles_written), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst.after_done",  32'(tile_done), 0);
    chk("mrst.after_we",    32'(mem_we), 0);
    chk("mrst.after_count", 32'(tiles_written), 0);

    // Recovery after reset
    send(2'b00, 'h3F800000, 'h0, 'h0, 'h0, 16'h0005, 16'd8);
    exp_wr("recov.c11", 'h5, 'h3F800000);
    exp_done("recov", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
